// File: rtl/System_Pkg.sv
// Shared codebase types: the global clock/reset bundle, issue width and
// the occupancy encoding used by pipeline skid registers.
package System_Pkg;

    typedef struct packed {
        logic Clk;
        logic Rst;
    } Global;

    localparam int ISSUE_LANES = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HALF  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register: a main entry drives the outputs and a
// skid entry absorbs one packet of backpressure so In_Ready is a pure flop.
module pipe_skid_reg
    import System_Pkg::*;
#(
    parameter int              WIDTH     = 32,
    parameter int              LANES     = ISSUE_LANES,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(32'h3000)
) (
    input  Global                         System,
    input  logic                          Flush,
    input  logic                          In_Valid,
    output logic                          In_Ready,
    input  logic [LANES-1:0]              In_Mask,
    input  logic [LANES-1:0][WIDTH-1:0]   In_Data,
    output logic                          Out_Valid,
    input  logic                          Out_Ready,
    output logic [LANES-1:0]              Out_Mask,
    output logic [LANES-1:0][WIDTH-1:0]   Out_Data
);

    occ_e                         occ_q, occ_d;
    logic                         in_ready_q, in_ready_d;
    logic                         out_valid_q, out_valid_d;
    logic [LANES-1:0]             main_mask_q, main_mask_d;
    logic [LANES-1:0]             skid_mask_q, skid_mask_d;
    logic [LANES-1:0][WIDTH-1:0]  main_data_q, main_data_d;
    logic [LANES-1:0][WIDTH-1:0]  skid_data_q, skid_data_d;
    logic                         up_xfer;
    logic                         down_xfer;

    assign up_xfer   = In_Valid && in_ready_q;
    assign down_xfer = out_valid_q && Out_Ready;

    always_comb begin
        occ_d       = occ_q;
        main_mask_d = main_mask_q;
        main_data_d = main_data_q;
        skid_mask_d = skid_mask_q;
        skid_data_d = skid_data_q;

        case (occ_q)
            OCC_EMPTY: begin
                if (up_xfer) begin
                    main_mask_d = In_Mask;
                    main_data_d = In_Data;
                    occ_d       = OCC_HALF;
                end
            end
            OCC_HALF: begin
                if (up_xfer && down_xfer) begin
                    main_mask_d = In_Mask;
                    main_data_d = In_Data;
                end else if (up_xfer) begin
                    skid_mask_d = In_Mask;
                    skid_data_d = In_Data;
                    occ_d       = OCC_FULL;
                end else if (down_xfer) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (down_xfer) begin
                    main_mask_d = skid_mask_q;
                    main_data_d = skid_data_q;
                    occ_d       = OCC_HALF;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase

        // Flush only drops the valid state; payload registers may hold stale data.
        if (Flush) begin
            occ_d = OCC_EMPTY;
        end

        in_ready_d  = (occ_d != OCC_FULL);
        out_valid_d = (occ_d != OCC_EMPTY);
    end

    always_ff @(posedge System.Clk) begin
        if (System.Rst) begin
            occ_q       <= OCC_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_mask_q <= '0;
            skid_mask_q <= '0;
            main_data_q <= {LANES{RESET_VAL}};
            skid_data_q <= {LANES{RESET_VAL}};
        end else begin
            occ_q       <= occ_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_mask_q <= main_mask_d;
            skid_mask_q <= skid_mask_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign In_Ready  = in_ready_q;
    assign Out_Valid = out_valid_q;
    assign Out_Mask  = main_mask_q;
    assign Out_Data  = main_data_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random-stall bench for pipe_skid_reg; a packet queue models
// the held entries and is compared against the outputs every cycle.
module tb_pipe_skid_reg;
    import System_Pkg::*;

    localparam int W = 32;
    localparam int L = ISSUE_LANES;

    typedef struct packed {
        logic [L-1:0]        mask;
        logic [L-1:0][W-1:0] data;
    } pkt_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    Global               sys;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [L-1:0]        in_mask = '0;
    logic [L-1:0][W-1:0] in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [L-1:0]        out_mask;
    logic [L-1:0][W-1:0] out_data;

    pkt_t model_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   model_known = 1'b0;
    bit   after_reset = 1'b0;

    assign sys = {clk, rst};

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .WIDTH    (W),
        .LANES    (L),
        .RESET_VAL(32'h3000)
    ) dut (
        .System   (sys),
        .Flush    (flush),
        .In_Valid (in_valid),
        .In_Ready (in_ready),
        .In_Mask  (in_mask),
        .In_Data  (in_data),
        .Out_Valid(out_valid),
        .Out_Ready(out_ready),
        .Out_Mask (out_mask),
        .Out_Data (out_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string label);
        logic [L-1:0][W-1:0] reset_data;
        reset_data = {L{32'h3000}};
        check({label, "/in_ready"}, 64'(in_ready), 64'(model_q.size() < 2));
        check({label, "/out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            check({label, "/out_mask"}, 64'(out_mask), 64'(model_q[0].mask));
            check({label, "/out_data"}, 64'(out_data), 64'(model_q[0].data));
        end
        if (after_reset) begin
            check({label, "/rst_mask"}, 64'(out_mask), 64'd0);
            check({label, "/rst_data"}, 64'(out_data), 64'(reset_data));
        end
    endtask

    // Drive one cycle of inputs, compare outputs against the model, then advance the model at the edge.
    task automatic applyStimulus(input logic v, input logic [L-1:0] m, input logic [W-1:0] d0,
                                 input logic [W-1:0] d1, input logic ordy, input logic fl,
                                 input logic rs, input string label);
        pkt_t p;
        bit   exp_rdy;
        bit   exp_val;
        @(negedge clk);
        in_valid   = v;
        in_mask    = m;
        in_data[0] = d0;
        in_data[1] = d1;
        out_ready  = ordy;
        flush      = fl;
        rst        = rs;
        #1;
        if (model_known) checkOutput(label);
        exp_rdy = (model_q.size() < 2);
        exp_val = (model_q.size() > 0);
        @(posedge clk);
        if (rs) begin
            model_q.delete();
            model_known = 1'b1;
            after_reset = 1'b1;
        end else begin
            after_reset = 1'b0;
            if (fl) begin
                model_q.delete();
            end else begin
                if (exp_val && ordy) void'(model_q.pop_front());
                if (v && exp_rdy) begin
                    p.mask    = m;
                    p.data[0] = d0;
                    p.data[1] = d1;
                    model_q.push_back(p);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, "reset0");
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, "reset1");
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, "reset_release");

        applyStimulus(1, 2'b11, 32'h11, 32'h22, 1, 0, 0, "stream_a");
        applyStimulus(1, 2'b11, 32'h33, 32'h44, 1, 0, 0, "stream_b");
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 0, "stream_out_b");
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 0, "stream_idle");

        applyStimulus(1, 2'b11, 32'hA0, 32'hA1, 0, 0, 0, "bp_a");
        applyStimulus(1, 2'b01, 32'hB0, 32'hB1, 0, 0, 0, "bp_b");
        applyStimulus(1, 2'b10, 32'hC0, 32'hC1, 0, 0, 0, "bp_c_held");
        applyStimulus(1, 2'b10, 32'hC0, 32'hC1, 0, 0, 0, "bp_c_held2");
        applyStimulus(1, 2'b10, 32'hC0, 32'hC1, 1, 0, 0, "bp_drain_a");
        applyStimulus(1, 2'b10, 32'hC0, 32'hC1, 1, 0, 0, "bp_c_accept");
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 0, "bp_drain_c");
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 0, "bp_empty");

        applyStimulus(1, 2'b11, 32'hD0, 32'hD1, 0, 0, 0, "sim_load_a");
        applyStimulus(1, 2'b11, 32'hE0, 32'hE1, 1, 0, 0, "sim_swap");
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, "sim_main_b");
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 0, "sim_drain");

        applyStimulus(1, 2'b11, 32'h100, 32'h101, 0, 0, 0, "fl_a");
        applyStimulus(1, 2'b11, 32'h200, 32'h201, 0, 0, 0, "fl_b");
        applyStimulus(1, 2'b11, 32'h300, 32'h301, 0, 1, 0, "fl_flush");
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 0, "fl_after");

        applyStimulus(1, 2'b00, 32'h55, 32'h66, 1, 0, 0, "bubble_in");
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 0, "bubble_out");

        applyStimulus(1, 2'b11, 32'h400, 32'h401, 0, 0, 0, "rf_a");
        applyStimulus(1, 2'b01, 32'h500, 32'h501, 0, 0, 0, "rf_b");
        applyStimulus(1, 2'b11, 32'h600, 32'h601, 0, 1, 1, "rf_reset");
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 0, "rf_after");

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), $urandom, $urandom,
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0), 0, "rand");
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 2'b00, 0, 0, 1, 0, 0, "drain");
        end
        check("drain_model_empty", 64'(model_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 32, bits per lane.
- LANES, default 2, issue lanes per packet.
- RESET_VAL, default 32'h3000, reset value of every lane's data.
REQ-002 Ports SHALL be:
- System  input  Global  codebase clock/reset bundle; System.Clk is the single clock, System.Rst is a synchronous, active-high reset.
- Flush  input  1  discard all held packets.
- In_Valid  input  1  upstream packet valid.
- In_Ready  output  1  block can accept a packet this cycle.
- In_Mask  input  LANES  per-lane valid mask.
- In_Data  input  LANES x WIDTH  lane payloads.
- Out_Valid  output  1  downstream packet valid.
- Out_Ready  input  1  downstream accepts this cycle.
- Out_Mask  output  LANES  per-lane mask of the head packet.
- Out_Data  output  LANES x WIDTH  head packet payloads.

Function
REQ-003 The block SHALL be a 2-entry skid pipeline register holding a main entry (drives Out_*) and a skid entry.
REQ-004 An upstream transfer SHALL occur when In_Valid && In_Ready; a downstream transfer SHALL occur when Out_Valid && Out_Ready.
REQ-005 In_Ready SHALL equal !skid_valid and SHALL come straight from a flop, with no combinational path from Out_Ready.
REQ-006 Latency from upstream transfer to Out_Valid SHALL be 1 cycle when the main entry is empty or drains in the same cycle.
REQ-007 Occupancy states SHALL be EMPTY (0), HALF (main only) and FULL (main+skid). Transitions:
- EMPTY->HALF on an upstream transfer.
- HALF->EMPTY on a downstream transfer without an upstream transfer.
- HALF->HALF on simultaneous transfers; the main entry reloads.
- HALF->FULL on an upstream transfer without a downstream transfer; the new packet goes to skid.
- FULL->HALF on a downstream transfer; skid moves to main.
REQ-008 No upstream transfer SHALL occur in FULL, because In_Ready is 0.
REQ-009 Packet order SHALL be preserved; no packet SHALL be duplicated or dropped except by Flush or reset.
REQ-010 Out_Data and Out_Mask SHALL stay stable while Out_Valid && !Out_Ready.
REQ-011 Flush SHALL clear both valid flags on the next edge. Flush SHALL have priority over a simultaneous upstream transfer, whose packet is discarded. Data registers MAY keep stale values.
REQ-012 A packet with In_Mask == 0 SHALL still be a valid packet (bubble) and SHALL be carried with an all-zero Out_Mask.
REQ-013 Out_Mask and Out_Data SHALL be meaningful only while Out_Valid is 1.

Reset
REQ-014 On System.Rst at a System.Clk edge, the block SHALL reset as follows:
- main and skid valid flags = 0;
- Out_Valid = 0 and In_Ready = 1 on the following cycle;
- Out_Mask = 0 and every lane of Out_Data = RESET_VAL;
- skid data = RESET_VAL and skid mask = 0.
REQ-015 Reset SHALL override Flush and any transfer; reset asserted mid-operation SHALL discard held packets.
REQ-016 The block SHALL hold no asynchronous logic.

Structure
REQ-017 The Global bundle typedef SHALL stay in System_Pkg. A constant ISSUE_LANES (=2) SHALL be added there and used as the LANES default by instantiating stages.
REQ-018 The block SHALL use no sub-module; both entries SHALL be inline flops with one next-state block for valid/occupancy control.
REQ-019 The block SHALL be instantiable between every pipeline stage, including for LANES=1, and SHALL compile with WIDTH from 1 to 64.

Verification
REQ-020 Reset release: hold System.Rst for 2 cycles, then deassert -> Out_Valid=0, In_Ready=1, Out_Data lanes=32'h3000, Out_Mask=2'b00.
REQ-021 Streaming: packets A=(0x11,0x22) then B=(0x33,0x44) with mask 2'b11, Out_Ready=1 -> A appears 1 cycle after its transfer and B on the next cycle; In_Ready stays 1 throughout.
REQ-022 Backpressure fill: Out_Ready=0 while sending A, B, C -> A and B are accepted and In_Ready drops after B; C is held upstream. Raise Out_Ready -> A, B, C are delivered in order.
REQ-023 Simultaneous transfer in HALF: main=A, send B while Out_Ready=1 -> next cycle Out_Data=B and the skid entry stays empty (In_Ready=1).
REQ-024 Flush in FULL together with In_Valid=1 -> next cycle Out_Valid=0 and In_Ready=1; the incoming packet never appears at the output.
REQ-025 Bubble and reset mid-FULL:
- a packet with mask 2'b00 is delivered with Out_Mask=2'b00;
- reset asserted in FULL -> the next cycle is empty, and a random-stall scoreboard shows no loss or duplication outside flush/reset.
